multiword_add_seq: RTL and testbench

//  Sequencer that runs one shared adder_16bit over WORDS cycles to add or subtract
//  two (16*WORDS)-bit operands, least significant word first, with a registered carry.

---
 rtl/multiword_add_seq_pkg.sv | 15 +
 rtl/multiword_add_seq_if.sv | 29 ++
 rtl/multiword_add_seq_adder_16bit.sv | 14 +
 rtl/multiword_add_seq.sv | 87 ++++++++
 tb/tb_multiword_add_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/multiword_add_seq_pkg.sv
// Shared word width, FSM encodings and result flag bundle for the multiword adder.
// No logic; constants and types only.
// Imported by the interface, the adder and the sequencer.
package multiword_add_seq_pkg;
  localparam int WORD_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic c_out;
    logic overflow;
  } flags_t;
endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/result bundle between a wide-arithmetic requester and the sequencer.
// No latency; wires only.
// Valid/ready on both the request side and the result side.
interface multiword_add_seq_if #(parameter int WORDS = 4);
  import multiword_add_seq_pkg::*;
  localparam int W = WORD_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/multiword_add_seq_adder_16bit.sv
// 16-bit ripple adder with carry in/out, shared by the word sequencer.
// Purely combinational.
// No handshake.
module adder_16bit
  import multiword_add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              c_in,
  output logic [WORD_W-1:0] sum,
  output logic              c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, c_in};
endmodule

// File: rtl/multiword_add_seq.sv
// Adds/subtracts two WORDS x 16-bit operands through one adder_16bit, LS word first.
// Latency: out_valid rises WORDS edges after the accept edge.
// Accepts only in IDLE; result is held in DONE until out_ready.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multiword_add_seq_if.slave   bus
);
  localparam int W     = WORD_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      sum_reg;
  logic              carry;
  flags_t            flags;

  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] add_sum;
  logic              add_c;

  assign a_word = a_reg[idx*WORD_W +: WORD_W];
  assign b_word = b_reg[idx*WORD_W +: WORD_W];

  adder_16bit u_adder_16bit (
    .a     (a_word),
    .b     (b_word),
    .c_in  (carry),
    .sum   (add_sum),
    .c_out (add_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      flags   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is folded into the operands: A + ~B + 1.
            a_reg <= bus.a;
            b_reg <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.c_in;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_reg[idx*WORD_W +: WORD_W] <= add_sum;
          carry <= add_c;
          if (idx == IDX_LAST) begin
            flags.c_out    <= add_c;
            flags.overflow <= (a_reg[W-1] == b_reg[W-1]) &&
                              (add_sum[WORD_W-1] != a_reg[W-1]);
            state          <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.sum       = sum_reg;
  assign bus.c_out     = flags.c_out;
  assign bus.overflow  = flags.overflow;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq (WORDS=4): directed vectors, queue of expected results.
module tb_multiword_add_seq;
  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  multiword_add_seq_if #(.WORDS(4)) bus();

  multiword_add_seq #(.WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares each result at the cycle it is handed over.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got sum 0x%0h, expected no result", bus.sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", bus.sum, e.s);
        check("c_out", {63'd0, bus.c_out}, {63'd0, e.c});
        check("overflow", {63'd0, bus.overflow}, {63'd0, e.o});
      end
    end
  end

  task automatic wait_valid(output int lat);
    bit found;
    found = 0;
    lat = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid === 1'b1) found = 1;
    end
  endtask

  task automatic issue(input logic [63:0] a_v, input logic [63:0] b_v,
                       input logic sub_v, input logic cin_v);
    @(negedge clk);
    check("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
    bus.a        = a_v;
    bus.b        = b_v;
    bus.sub      = sub_v;
    bus.c_in     = cin_v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [63:0] a_v, input logic [63:0] b_v,
                       input logic sub_v, input logic cin_v,
                       input logic [63:0] es, input logic ec, input logic eo);
    int lat;
    exp_q.push_back(exp_t'{s: es, c: ec, o: eo});
    issue(a_v, b_v, sub_v, cin_v);
    wait_valid(lat);
    check("latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;

    // Async reset asserted between edges.
    #12 rst = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_sum", bus.sum, 64'd0);
    check("rst_c_out", {63'd0, bus.c_out}, 64'd0);
    check("rst_overflow", {63'd0, bus.overflow}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
    do_op(64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0);
    // sub ignores c_in; equal operands give zero with no borrow.
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0);

    // Backpressure: result must hold while a new request waits.
    bus.out_ready = 1'b0;
    exp_q.push_back(exp_t'{s: 64'h3333_3333_3333_3333, c: 1'b0, o: 1'b0});
    issue(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd4);
    bus.a        = 64'h5;
    bus.b        = 64'h5;
    bus.sub      = 1'b0;
    bus.c_in     = 1'b0;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp_t'{s: 64'hA, c: 1'b0, o: 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_sum_stable", bus.sum, 64'h3333_3333_3333_3333);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_back_to_idle", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp_next_latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;

    // Reset mid-RUN at idx==2 aborts without a result.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("abort_sum", bus.sum, 64'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", {63'd0, bus.out_valid}, 64'd0);
    end
    do_op(64'h1234, 64'h1, 1'b0, 1'b0, 64'h1235, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
